cordic_iter_ctrl: RTL and testbench

//  Iterative CORDIC sequencer; drives one combinational core through the controller modport of cordic_if.

---
 rtl/cordic_pkg.sv | 33 +++
 rtl/cordic_if.sv | 25 ++
 rtl/cordic_core.sv | 28 ++
 rtl/cordic_iter_ctrl.sv | 90 +++++++++
 tb/tb_cordic_iter_ctrl.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/cordic_pkg.sv
// cordic_pkg: shared CORDIC constants, binary-angle arctangent table and encodings
package cordic_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} cordic_state_e;
    typedef enum logic {CORDIC_ROT = 1'b0, CORDIC_VEC = 1'b1} cordic_mode_e;

    localparam logic [31:0] CORDIC_K_Q2_30 = 32'h6964_8523;

    localparam logic [127:0] INV_2PI_Q128 = 128'h28BE_60DB_9391_054A_7F09_D5F4_7D4D_3770;

    function automatic logic [63:0] atan_bam(input int i);
        logic [255:0] acc;
        logic [255:0] term;
        logic [255:0] prod;
        if (i == 0) return 64'h2000_0000_0000_0000;
        acc = '0;
        for (int k = 0; (2 * k + 1) * i < 128; k++) begin
            term = (256'd1 << (128 - (2 * k + 1) * i)) / 256'(2 * k + 1);
            acc = k[0] ? acc - term : acc + term;
        end
        prod = acc * {128'd0, INV_2PI_Q128};
        return prod[255:192];
    endfunction

    function automatic logic [0:63][63:0] build_atan_table();
        logic [0:63][63:0] t;
        for (int i = 0; i < 64; i++) t[i] = atan_bam(i);
        return t;
    endfunction

    localparam logic [0:63][63:0] ATAN_TABLE = build_atan_table();

endpackage

// File: rtl/cordic_if.sv
// cordic_if: link between the iteration controller and one combinational micro-rotation core
interface cordic_if import cordic_pkg::*; #(
    parameter int p_WIDTH = 32
);
    localparam int p_LOG2_WIDTH = $clog2(p_WIDTH);

    logic signed [p_WIDTH-1:0]  xprev, yprev, zprev;
    logic signed [p_WIDTH-1:0]  xnext, ynext, znext;
    cordic_mode_e               mode;
    logic [p_LOG2_WIDTH-1:0]    shift_amnt;
    logic [p_WIDTH-1:0]         angle;
    logic                       dir;
    logic                       xOverflow, yOverflow, zOverflow;

    modport controller (
        output xprev, yprev, zprev, mode, shift_amnt, angle, dir,
        input  xnext, ynext, znext, xOverflow, yOverflow, zOverflow
    );

    modport core (
        input  xprev, yprev, zprev, mode, shift_amnt, angle, dir,
        output xnext, ynext, znext, xOverflow, yOverflow, zOverflow
    );

endinterface

// File: rtl/cordic_core.sv
// cordic_core: one combinational micro-rotation, wrapping results with per-lane overflow flags
module cordic_core import cordic_pkg::*; #(
    parameter int p_WIDTH = 32
) (
    cordic_if.core bus
);
    logic signed [p_WIDTH:0] x_sh, y_sh, x_sum, y_sum, z_sum, a_ext;

    // one guard bit so the overflow of each lane is visible as a top-bit disagreement
    always_comb begin
        x_sh  = $signed({bus.xprev[p_WIDTH-1], bus.xprev}) >>> bus.shift_amnt;
        y_sh  = $signed({bus.yprev[p_WIDTH-1], bus.yprev}) >>> bus.shift_amnt;
        a_ext = $signed({1'b0, bus.angle});
        x_sum = bus.dir ? $signed({bus.xprev[p_WIDTH-1], bus.xprev}) - y_sh
                        : $signed({bus.xprev[p_WIDTH-1], bus.xprev}) + y_sh;
        y_sum = bus.dir ? $signed({bus.yprev[p_WIDTH-1], bus.yprev}) + x_sh
                        : $signed({bus.yprev[p_WIDTH-1], bus.yprev}) - x_sh;
        z_sum = bus.dir ? $signed({bus.zprev[p_WIDTH-1], bus.zprev}) - a_ext
                        : $signed({bus.zprev[p_WIDTH-1], bus.zprev}) + a_ext;
        bus.xnext     = x_sum[p_WIDTH-1:0];
        bus.ynext     = y_sum[p_WIDTH-1:0];
        bus.znext     = z_sum[p_WIDTH-1:0];
        bus.xOverflow = x_sum[p_WIDTH] ^ x_sum[p_WIDTH-1];
        bus.yOverflow = y_sum[p_WIDTH] ^ y_sum[p_WIDTH-1];
        bus.zOverflow = z_sum[p_WIDTH] ^ z_sum[p_WIDTH-1];
    end

endmodule

// File: rtl/cordic_iter_ctrl.sv
// cordic_iter_ctrl: runs p_ITER micro-rotations, one per clock, through an external CORDIC core
module cordic_iter_ctrl import cordic_pkg::*; #(
    parameter int p_WIDTH = 32,
    parameter int p_ITER  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_mode,
    input  logic signed [p_WIDTH-1:0] in_x,
    input  logic signed [p_WIDTH-1:0] in_y,
    input  logic signed [p_WIDTH-1:0] in_z,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [p_WIDTH-1:0] out_x,
    output logic signed [p_WIDTH-1:0] out_y,
    output logic signed [p_WIDTH-1:0] out_z,
    output logic [2:0]                out_ovf,
    cordic_if.controller              core
);
    localparam int p_LOG2_WIDTH = $clog2(p_WIDTH);
    localparam int ITER_W       = p_LOG2_WIDTH + 1;
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(p_ITER - 1);

    cordic_state_e             state, state_nxt;
    logic [ITER_W-1:0]         iter;
    logic signed [p_WIDTH-1:0] x_q, y_q, z_q;
    cordic_mode_e              mode_q;
    logic [2:0]                ovf_q;
    logic                      accept;

    assign accept    = in_valid && in_ready;
    assign out_x     = x_q;
    assign out_y     = y_q;
    assign out_z     = z_q;
    assign out_ovf   = ovf_q;

    assign core.xprev      = x_q;
    assign core.yprev      = y_q;
    assign core.zprev      = z_q;
    assign core.mode       = mode_q;
    assign core.shift_amnt = iter[p_LOG2_WIDTH-1:0];
    assign core.angle      = ATAN_TABLE[iter][63 -: p_WIDTH];
    assign core.dir        = mode_q == CORDIC_VEC ? y_q[p_WIDTH-1] : !z_q[p_WIDTH-1];

    // state register
    always_ff @(posedge clk) begin
        state <= !rst_n ? IDLE : state_nxt;
    end

    // handshakes and next state
    always_comb begin
        state_nxt = state;
        in_ready  = state == IDLE;
        out_valid = state == DONE;
        case (state)
            IDLE:    state_nxt = in_valid ? RUN : IDLE;
            RUN:     state_nxt = iter == ITER_LAST ? DONE : RUN;
            DONE:    state_nxt = out_ready ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // operand load, per-iteration update and sticky overflow collection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            iter   <= '0;
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
            mode_q <= CORDIC_ROT;
            ovf_q  <= '0;
        end else if (accept) begin
            iter   <= '0;
            x_q    <= in_x;
            y_q    <= in_y;
            z_q    <= in_z;
            mode_q <= cordic_mode_e'(in_mode);
            ovf_q  <= '0;
        end else if (state == RUN) begin
            iter   <= iter + 1'b1;
            x_q    <= core.xnext;
            y_q    <= core.ynext;
            z_q    <= core.znext;
            ovf_q  <= ovf_q | {core.zOverflow, core.yOverflow, core.xOverflow};
        end
    end

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// tb_cordic_iter_ctrl: directed checks of the CORDIC sequencer bound to the reference core
module tb_cordic_iter_ctrl;
    localparam int W = 32;
    localparam int N = 16;
    localparam logic [31:0] K_DIAG = 32'h4A86_1BD6;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_mode = 1'b0;
    logic                out_ready = 1'b0;
    logic signed [W-1:0] in_x = '0, in_y = '0, in_z = '0;
    logic                in_ready, out_valid;
    logic signed [W-1:0] out_x, out_y, out_z;
    logic [2:0]          out_ovf;
    int                  checks = 0;
    int                  errors = 0;

    always #5 clk = ~clk;

    cordic_if #(.p_WIDTH(W)) cif ();

    cordic_core #(.p_WIDTH(W)) u_core (.bus(cif));

    cordic_iter_ctrl #(.p_WIDTH(W), .p_ITER(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_x(in_x), .in_y(in_y), .in_z(in_z),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_z(out_z), .out_ovf(out_ovf),
        .core(cif)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp, input int tol = 0);
        longint d;
        d = longint'(int'(got - exp));
        if (d < 0) d = -d;
        checks++;
        if ($isunknown(got) || (tol == 0 ? got !== exp : d > tol)) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h tol 0x%0h", tag, got, exp, tol);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // present one operand for the accepting edge, then scramble the inputs
    task automatic send(input logic mode, input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        in_mode  = mode;
        in_x     = x;
        in_y     = y;
        in_z     = z;
        in_valid = 1'b1;
        check("accept_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        in_mode  = ~mode;
        in_x     = 32'hDEAD_BEEF;
        in_y     = 32'h1234_5678;
        in_z     = 32'h7FFF_FFFF;
    endtask

    task automatic wait_done(input string tag);
        int lat;
        lat = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
        check(tag, lat, N);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] sx, sy, sz;
        int acc_c[$];

        repeat (3) step();
        rst_n = 1'b1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_ovf", out_ovf, 0);
        check("rst_x", out_x, 0);
        check("rst_z", out_z, 0);

        // rotation of (1.0, 0) by 45 degrees
        send(1'b0, 32'h4000_0000, 32'h0, 32'h2000_0000);
        wait_done("t1_latency");
        check("t1_x", out_x, K_DIAG, 32'h8000);
        check("t1_y", out_y, K_DIAG, 32'h8000);
        check("t1_z", out_z, 32'h0, 32'hFFFF);
        check("t1_ovf", out_ovf, 0);
        check("t1_done_ready", in_ready, 0);
        consume();
        check("t1_idle_valid", out_valid, 0);
        check("t1_idle_ready", in_ready, 1);

        // vectoring of (0.5, 0.5), then backpressure on its result
        send(1'b1, 32'h2000_0000, 32'h2000_0000, 32'h0);
        wait_done("t2_latency");
        check("t2_z", out_z, 32'h2000_0000, 32'hFFFF);
        check("t2_y", out_y, 32'h0, 32'h7FFF);
        check("t2_x", out_x, 32'h4A86_0000, 32'h8000);
        check("t2_ovf", out_ovf, 0);
        sx = out_x;
        sy = out_y;
        sz = out_z;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t3_valid", out_valid, 1);
            check("t3_ready", in_ready, 0);
            check("t3_x", out_x, sx);
            check("t3_y", out_y, sy);
            check("t3_z", out_z, sz);
        end
        consume();
        check("t3_idle_ready", in_ready, 1);
        check("t3_idle_valid", out_valid, 0);

        // overflow on the first vectoring step, sticky into IDLE
        send(1'b1, 32'h7000_0000, 32'h7000_0000, 32'h0);
        wait_done("t4_latency");
        check("t4_ovf_x", out_ovf[0], 1);
        consume();
        step();
        check("t4_ovf_idle", out_ovf[0], 1);

        // a new accept clears it; the reset at iter 7 aborts the operation
        send(1'b1, 32'h7000_0000, 32'h7000_0000, 32'h0);
        check("t4_ovf_cleared", out_ovf, 0);
        repeat (7) step();
        check("t5_ovf_before_rst", out_ovf[0], 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("t5_in_ready", in_ready, 1);
        check("t5_out_valid", out_valid, 0);
        check("t5_ovf", out_ovf, 0);
        send(1'b0, 32'h4000_0000, 32'h0, 32'h2000_0000);
        wait_done("t5_latency");
        check("t5_x", out_x, K_DIAG, 32'h8000);
        check("t5_y", out_y, K_DIAG, 32'h8000);
        check("t5_z", out_z, 32'h0, 32'hFFFF);
        check("t5_res_ovf", out_ovf, 0);
        consume();

        // in_valid held high with a free sink: one accept every p_ITER+2 cycles
        in_mode   = 1'b0;
        in_x      = 32'h4000_0000;
        in_y      = 32'h0;
        in_z      = 32'h2000_0000;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 3 * (N + 2); c++) begin
            if (in_ready) acc_c.push_back(c);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("t6_accepts", acc_c.size(), 3);
        if (acc_c.size() == 3) begin
            check("t6_gap1", acc_c[1] - acc_c[0], N + 2);
            check("t6_gap2", acc_c[2] - acc_c[1], N + 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
